ps2_host_rx: RTL and testbench

Host-side PS/2 receiver for the core. It deserialises the keyboard stream that `user_io` emulates on `ps2_clk`/`ps2_data` into scancode bytes for the MSX keyboard matrix logic. It synchronises and filters both lines, checks start, parity and stop bits, aborts stalled frames, and presents bytes through a valid/ack handshake. It sits between the `user_io` PS/2 outputs and the keyboard decoder, and runs in the core system clock domain.

---
 rtl/ps2_pkg.sv | 14 +
 rtl/ps2_line_filter.sv | 48 ++++
 rtl/ps2_host_rx.sv | 191 +++++++++++++++++++
 tb/tb_ps2_host_rx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_rx_state_t;

  localparam int PS2_FIFO_DEPTH = 8;
  localparam int PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus glitch filter for one PS/2 line.
// level_o only changes after FILTER_LEN equal synchronised samples; fall_o is a registered 1->0 pulse.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          fall_q;

  // cnt_q counts consecutive samples that disagree with the accepted level
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync_q[1];
      else                   cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], line_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      fall_q  <= level_q & ~level_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_rx.sv
// PS/2 host receiver: filtered lines, frame FSM with odd parity and stall timeout, valid/ack output buffer.
// Define PS2_RX_FIFO_EN to replace the single holding register with an 8-entry FIFO.
module ps2_host_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 8192
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_err,
  output logic       rx_ovr
);

  // Handshake: rx_valid is a level while a byte is held; rx_ack pops it only when sampled with rx_valid=1.

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_HIT = TW'(TIMEOUT_CYC - 2);

  logic clk_fall, clk_level_unused;
  logic data_level, data_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .reset_n(reset_n), .line_i(ps2_clk),
    .level_o(clk_level_unused), .fall_o(clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk(clk), .reset_n(reset_n), .line_i(ps2_data),
    .level_o(data_level), .fall_o(data_fall_unused)
  );

  ps2_rx_state_t state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          bad_q, bad_d;
  logic          err_q, err_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_hit;
  logic          push;

  // Firing one count early makes the registered rx_err land exactly TIMEOUT_CYC cycles after the fall.
  assign to_cnt_d    = clk_fall ? '0 : ((to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1);
  assign timeout_hit = (state_q != IDLE) && (to_cnt_q == TO_HIT);

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    bad_d    = bad_q;
    err_d    = 1'b0;
    push     = 1'b0;
    if (clk_fall) begin
      case (state_q)
        IDLE: begin
          if (!data_level) begin
            state_d  = DATA;
            bitcnt_d = '0;
            par_d    = 1'b1;
            bad_d    = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d  = {data_level, shift_q[7:1]};
          par_d    = par_q ^ data_level;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          if (data_level != par_q) bad_d = 1'b1;
          state_d = STOP;
        end
        STOP: begin
          if (data_level && !bad_q) push  = 1'b1;
          else                      err_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b1;
      bad_q    <= 1'b0;
      err_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      bad_q    <= bad_d;
      err_q    <= err_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign rx_err = err_q;

  logic ovr_q;

`ifdef PS2_RX_FIFO_EN
  logic [7:0] mem_q [PS2_FIFO_DEPTH];
  logic [2:0] wr_q, rd_q;
  logic       full_q, empty, pop, push_ok;

  assign empty   = (wr_q == rd_q) && !full_q;
  assign pop     = rx_ack && !empty;
  assign push_ok = push && (!full_q || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PS2_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      full_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= shift_q;
        wr_q        <= wr_q + 3'd1;
      end
      if (pop) rd_q <= rd_q + 3'd1;
      if (push_ok && !pop && (wr_q + 3'd1 == rd_q)) full_q <= 1'b1;
      else if (pop && !push_ok)                     full_q <= 1'b0;
      ovr_q <= push && !push_ok;
    end
  end

  assign rx_data  = mem_q[rd_q];
  assign rx_valid = !empty;
`else
  logic [7:0] hold_q, hold_d;
  logic       valid_q, valid_d, ovr_d, pop;

  assign pop = rx_ack && valid_q;

  // A pop in the same cycle frees the slot, so the new byte is accepted without overflow.
  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (push) begin
      if (!valid_q || pop) begin
        hold_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data  = hold_q;
  assign rx_valid = valid_q;
`endif

  assign rx_ovr = ovr_q;

endmodule

// File: tb/tb_ps2_host_rx.sv
// Directed bench for ps2_host_rx: good frames, parity error, timeout, overflow, glitch and mid-frame reset.
module tb_ps2_host_rx;
  import ps2_pkg::*;

  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 8192;
  localparam int HALF        = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_err, rx_ovr;

  ps2_host_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .rx_err(rx_err), .rx_ovr(rx_ovr)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;
  int last_fall_cyc = 0;
  int last_err_cyc = 0;
  int valid_rise_cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // event monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (dut.clk_fall) last_fall_cyc <= cyc;
    if (rx_err) begin
      err_cnt      <= err_cnt + 1;
      last_err_cyc <= cyc;
    end
    if (rx_ovr) ovr_cnt <= ovr_cnt + 1;
    if (rx_valid && !prev_valid) valid_rise_cyc <= cyc;
    prev_valid <= rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par);
    logic p;
    p = ~^b;
    if (bad_par) p = ~p;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    wait_cyc(HALF);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bits(make_frame(b, bad_par), PS2_FRAME_BITS);
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    wait_cyc(1);
    rx_ack = 1'b0;
  endtask

  task automatic wait_err(input int e0, input int limit);
    for (int i = 0; i < limit && err_cnt == e0; i++) wait_cyc(1);
    wait_cyc(2);
  endtask

  int e0, o0, f0;
  logic [10:0] fr;

  initial begin
    wait_cyc(5);
    reset_n = 1'b1;
    wait_cyc(5);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_err", rx_err, 1'b0);
    check("rst_ovr", rx_ovr, 1'b0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));

    // 0x1C: data 0,0,1,1,1,0,0,0, parity 0
    e0 = err_cnt;
    send_bits(11'b1_0_00011100_0, PS2_FRAME_BITS);
    check("1c_valid", rx_valid, 1'b1);
    check("1c_data", rx_data, 8'h1C);
    check("1c_latency", valid_rise_cyc - last_fall_cyc, 1);
    check("1c_no_err", err_cnt - e0, 0);
    do_ack();
    check("1c_popped", rx_valid, 1'b0);

    // 0xF0 with parity 0 (needs 1), then 0x00 with parity 1
    e0 = err_cnt;
    send_bits(11'b1_0_11110000_0, PS2_FRAME_BITS);
    check("par_err_pulse", err_cnt - e0, 1);
    check("par_no_valid", rx_valid, 1'b0);
    send_bits(11'b1_1_00000000_0, PS2_FRAME_BITS);
    check("00_valid", rx_valid, 1'b1);
    check("00_data", rx_data, 8'h00);
    do_ack();

    // abort after start + 4 data bits with ps2_clk held high
    e0 = err_cnt;
    send_bits(make_frame(8'hA5, 1'b0), 5);
    wait_err(e0, TIMEOUT_CYC + 200);
    check("to_err_pulse", err_cnt - e0, 1);
    check("to_latency", last_err_cyc - last_fall_cyc, TIMEOUT_CYC);
    check("to_state", 32'(dut.state_q), 32'(IDLE));
    check("to_no_valid", rx_valid, 1'b0);
    send_bits(11'b1_1_01011010_0, PS2_FRAME_BITS);
    check("5a_valid", rx_valid, 1'b1);
    check("5a_data", rx_data, 8'h5A);
    do_ack();

    // overflow
    e0 = err_cnt;
    o0 = ovr_cnt;
`ifdef PS2_RX_FIFO_EN
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 1'b0);
    check("fifo_ovr", ovr_cnt - o0, 1);
    check("fifo_no_err", err_cnt - e0, 0);
    for (int i = 0; i < 8; i++) begin
      check("fifo_valid", rx_valid, 1'b1);
      check("fifo_order", rx_data, 8'h10 + 8'(i));
      do_ack();
    end
    check("fifo_empty", rx_valid, 1'b0);
`else
    send_bits(11'b1_1_00010010_0, PS2_FRAME_BITS);
    send_bits(11'b1_0_00110100_0, PS2_FRAME_BITS);
    check("ovr_valid", rx_valid, 1'b1);
    check("ovr_data_kept", rx_data, 8'h12);
    check("ovr_pulse", ovr_cnt - o0, 1);
    check("ovr_no_err", err_cnt - e0, 0);
    do_ack();
    check("ovr_popped", rx_valid, 1'b0);
`endif

    // 2-cycle glitch on ps2_clk while idle
    e0 = err_cnt;
    f0 = last_fall_cyc;
    ps2_clk = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b1;
    wait_cyc(20);
    check("glitch_no_fall", last_fall_cyc - f0, 0);
    check("glitch_state", 32'(dut.state_q), 32'(IDLE));
    check("glitch_no_err", err_cnt - e0, 0);

    // reset mid-frame with a byte pending
    send_bits(11'b1_1_00110011_0, PS2_FRAME_BITS);
    check("pend_valid", rx_valid, 1'b1);
    fr = make_frame(8'h00, 1'b0);
    send_bits(fr, 4);
    reset_n = 1'b0;
    wait_cyc(3);
    check("mrst_valid", rx_valid, 1'b0);
    check("mrst_data", rx_data, 8'h00);
    check("mrst_err", rx_err, 1'b0);
    check("mrst_ovr", rx_ovr, 1'b0);
    check("mrst_state", 32'(dut.state_q), 32'(IDLE));
    reset_n = 1'b1;
    wait_cyc(3);
    e0 = err_cnt;
    send_bits(fr >> 4, 7);
    wait_cyc(TIMEOUT_CYC + 100);
    check("mrst_err_le1", 32'((err_cnt - e0) <= 1), 1);
    check("mrst_idle", 32'(dut.state_q), 32'(IDLE));
    check("mrst_no_valid", rx_valid, 1'b0);
    send_bits(11'b1_1_01110111_0, PS2_FRAME_BITS);
    check("77_valid", rx_valid, 1'b1);
    check("77_data", rx_data, 8'h77);
    do_ack();

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
